bcd_button_counter: RTL

- Parametrised successor to the single-button two-digit press counter.
- Debounces two independent buttons (increment, decrement) and keeps a DIGITS-wide BCD count with a configurable ceiling.
- Runtime-selectable wrap or saturate mode; drives one active-low 7-segment display per digit.
- Sits between raw board push-buttons and the display pins.

---
 rtl/bcd_button_counter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_button_counter.sv
// Purpose: debounces increment/decrement buttons and keeps a DIGITS-wide BCD count (wrap or saturate) with 7-segment decode.
// Latency: count updates DEBOUNCE_CYCLES+2 edges after the first edge that samples a button high; segments follow combinationally.
// Backpressure: none; presses are events and are never stalled, simultaneous inc+dec events cancel.
module bcd_button_counter #(
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_VALUE       = 99,
    parameter int BLANK_LZ        = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_inc,
    input  logic                  button_dec,
    input  logic                  wrap_en,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  wrap_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = 4 * DIGITS;

    // Elaboration-time binary to BCD for the ceiling.
    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] res;
        int            r;
        res = '0;
        r   = v;
        for (int k = 0; k < DIGITS; k++) begin
            res[4*k +: 4] = 4'(r % 10);
            r             = r / 10;
        end
        return res;
    endfunction

    localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_VALUE);

    // Ripple +1 across BCD digits, 9 rolls to 0 and carries upward.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        logic          c;
        res = v;
        c   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (v[4*k +: 4] == 4'd9) begin
                    res[4*k +: 4] = 4'd0;
                end else begin
                    res[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    c             = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Ripple -1 across BCD digits, 0 rolls to 9 and borrows upward.
    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        logic          b;
        res = v;
        b   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (v[4*k +: 4] == 4'd0) begin
                    res[4*k +: 4] = 4'd9;
                end else begin
                    res[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    b             = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Channel 0 = increment, channel 1 = decrement.
    logic [1:0]         raw;
    logic [1:0]         sync1_q, sync2_q, db_q, db_dly_q;
    logic [1:0][CW-1:0] cnt_q;
    logic [1:0]         press;
    logic [BW-1:0]      count_q, count_d;
    logic               wrap_q, wrap_d;

    assign raw   = {button_dec, button_inc};
    assign press = db_q & ~db_dly_q;

    // Two-flop synchroniser, debounce counter and debounced level per button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == db_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[b]  <= sync2_q[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CW'(1);
                end
            end
        end
    end

    // Next count: single inc or dec event moves the count; limits wrap or hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (press[0] && !press[1]) begin
            if (count_q != MAX_BCD) begin
                count_d = bcd_inc(count_q);
            end else if (wrap_en) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end
        end else if (press[1] && !press[0]) begin
            if (count_q != '0) begin
                count_d = bcd_dec(count_q);
            end else if (wrap_en) begin
                count_d = MAX_BCD;
                wrap_d  = 1'b1;
            end
        end
    end

    // Registered count and wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Segment decode from the top digit down so leading zeros can be blanked.
    always_comb begin
        logic       hi_zero;
        logic [3:0] dig;
        segments = '1;
        hi_zero  = 1'b1;
        dig      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dig     = count_q[4*k +: 4];
            hi_zero = hi_zero && (dig == 4'd0);
            if ((BLANK_LZ != 0) && (k > 0) && hi_zero) begin
                segments[7*k +: 7] = 7'h7F;
            end else begin
                segments[7*k +: 7] = seg_decode(dig);
            end
        end
    end

    assign count_bcd  = count_q;
    assign wrap_pulse = wrap_q;

endmodule
